// File: rtl/vx_fetch_queue_pkg.sv
// Shared widths and sizing helpers for the fetch stage.
package vx_fetch_queue_pkg;

  localparam int DEF_NUM_WARPS   = 4;
  localparam int DEF_NUM_THREADS = 4;
  localparam int DEF_PC_BITS     = 30;
  localparam int DEF_UUID_WIDTH  = 44;
  localparam int INSTR_WIDTH     = 32;
  localparam int PERF_CNT_WIDTH  = 32;

  // A single-warp core still needs a 1-bit warp id.
  function automatic int calc_nw_width(input int num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

  function automatic int calc_cnt_width(input int max_pending);
    return (max_pending > 1) ? $clog2(max_pending + 1) : 1;
  endfunction

endpackage

// File: rtl/vx_elastic_buffer.sv
// Small circular FIFO; data_out comes straight from storage flops.
module vx_elastic_buffer #(
  parameter int DATAW = 8,
  parameter int SIZE  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [DATAW-1:0] data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [DATAW-1:0] data_out
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(SIZE);
  localparam logic [AW-1:0] LAST_IDX = AW'(SIZE - 1);

  logic [DATAW-1:0] mem [SIZE];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  // ready_in depends only on occupancy, never on ready_out.
  assign ready_in  = (count != FULL_CNT);
  assign valid_out = (count != '0);
  assign data_out  = mem[rd_ptr];
  assign push      = valid_in & ready_in;
  assign pop       = valid_out & ready_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/vx_fetch_queue.sv
// Fetch stage: issues icache requests, keeps per-warp context, pairs
// out-of-order responses with that context and buffers them for decode.
module vx_fetch_queue
  import vx_fetch_queue_pkg::*;
#(
  parameter int NUM_WARPS   = DEF_NUM_WARPS,
  parameter int NUM_THREADS = DEF_NUM_THREADS,
  parameter int PC_BITS     = DEF_PC_BITS,
  parameter int UUID_WIDTH  = DEF_UUID_WIDTH,
  parameter int MAX_PENDING = NUM_WARPS,
  parameter bit PERF_ENABLE = 1'b1,
  localparam int NW_WIDTH   = calc_nw_width(NUM_WARPS),
  localparam int CNT_WIDTH  = calc_cnt_width(MAX_PENDING)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sched_valid,
  output logic                      sched_ready,
  input  logic [NW_WIDTH-1:0]       sched_wid,
  input  logic [NUM_THREADS-1:0]    sched_tmask,
  input  logic [PC_BITS-1:0]        sched_pc,
  input  logic [UUID_WIDTH-1:0]     sched_uuid,
  output logic                      icache_req_valid,
  input  logic                      icache_req_ready,
  output logic [PC_BITS-1:0]        icache_req_addr,
  output logic [NW_WIDTH-1:0]       icache_req_tag,
  input  logic                      icache_rsp_valid,
  output logic                      icache_rsp_ready,
  input  logic [INSTR_WIDTH-1:0]    icache_rsp_data,
  input  logic [NW_WIDTH-1:0]       icache_rsp_tag,
  output logic                      fetch_valid,
  input  logic                      fetch_ready,
  output logic [NW_WIDTH-1:0]       fetch_wid,
  output logic [NUM_THREADS-1:0]    fetch_tmask,
  output logic [PC_BITS-1:0]        fetch_pc,
  output logic [UUID_WIDTH-1:0]     fetch_uuid,
  output logic [INSTR_WIDTH-1:0]    fetch_instr,
  output logic [CNT_WIDTH-1:0]      pending_cnt,
  output logic                      busy,
  output logic [PERF_CNT_WIDTH-1:0] perf_req_stalls,
  output logic [PERF_CNT_WIDTH-1:0] perf_rsp_stalls
);

  typedef struct packed {
    logic [NUM_THREADS-1:0] tmask;
    logic [PC_BITS-1:0]     pc;
    logic [UUID_WIDTH-1:0]  uuid;
  } warp_ctx_t;

  typedef struct packed {
    logic [NW_WIDTH-1:0]    wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [PC_BITS-1:0]     pc;
    logic [UUID_WIDTH-1:0]  uuid;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_data_t;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_PENDING);

  warp_ctx_t            tag_table [NUM_WARPS];
  logic [NUM_WARPS-1:0] pend_mask;
  logic [NUM_WARPS-1:0] pend_mask_next;
  logic                 credit_ok;
  logic                 req_fire;
  logic                 rsp_fire;
  warp_ctx_t            rsp_ctx;
  fetch_data_t          buf_in;
  fetch_data_t          buf_out;

  // Request path is a pure pass-through gated by the credit counter.
  assign credit_ok        = (pending_cnt < MAX_CNT);
  assign icache_req_valid = sched_valid & credit_ok;
  assign sched_ready      = icache_req_ready & credit_ok;
  assign icache_req_addr  = sched_pc;
  assign icache_req_tag   = sched_wid;
  assign req_fire         = sched_valid & sched_ready;
  assign rsp_fire         = icache_rsp_valid & icache_rsp_ready;

  // Context storage is left unreset: a slot is only read after its write.
  always_ff @(posedge clk) begin
    if (req_fire) tag_table[sched_wid] <= '{tmask: sched_tmask, pc: sched_pc, uuid: sched_uuid};
  end

  assign rsp_ctx = tag_table[icache_rsp_tag];

  always_comb begin
    pend_mask_next = pend_mask;
    if (rsp_fire) pend_mask_next[icache_rsp_tag] = 1'b0;
    if (req_fire) pend_mask_next[sched_wid] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_mask   <= '0;
      pending_cnt <= '0;
    end else begin
      pend_mask <= pend_mask_next;
      case ({req_fire, rsp_fire})
        2'b10:   pending_cnt <= pending_cnt + CNT_WIDTH'(1);
        2'b01:   pending_cnt <= pending_cnt - CNT_WIDTH'(1);
        default: pending_cnt <= pending_cnt;
      endcase
    end
  end

  assign buf_in = '{wid: icache_rsp_tag, tmask: rsp_ctx.tmask, pc: rsp_ctx.pc,
                    uuid: rsp_ctx.uuid, instr: icache_rsp_data};

  vx_elastic_buffer #(
    .DATAW ($bits(fetch_data_t)),
    .SIZE  (2)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (icache_rsp_valid),
    .ready_in  (icache_rsp_ready),
    .data_in   (buf_in),
    .valid_out (fetch_valid),
    .ready_out (fetch_ready),
    .data_out  (buf_out)
  );

  assign fetch_wid   = buf_out.wid;
  assign fetch_tmask = buf_out.tmask;
  assign fetch_pc    = buf_out.pc;
  assign fetch_uuid  = buf_out.uuid;
  assign fetch_instr = buf_out.instr;
  assign busy        = (pending_cnt != '0) | fetch_valid;

  generate
    if (PERF_ENABLE) begin : g_perf
      logic [PERF_CNT_WIDTH-1:0] req_stalls_q;
      logic [PERF_CNT_WIDTH-1:0] rsp_stalls_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          req_stalls_q <= '0;
          rsp_stalls_q <= '0;
        end else begin
          if (sched_valid & ~sched_ready)           req_stalls_q <= req_stalls_q + PERF_CNT_WIDTH'(1);
          if (icache_rsp_valid & ~icache_rsp_ready) rsp_stalls_q <= rsp_stalls_q + PERF_CNT_WIDTH'(1);
        end
      end
      assign perf_req_stalls = req_stalls_q;
      assign perf_rsp_stalls = rsp_stalls_q;
    end else begin : g_no_perf
      assign perf_req_stalls = '0;
      assign perf_rsp_stalls = '0;
    end
  endgenerate

`ifndef SYNTHESIS
  // Both are scheduler/cache protocol violations; the datapath does not recover.
  always @(posedge clk) begin
    if (reset) begin
      if (req_fire)
        assert (!pend_mask[sched_wid]) else $error("fetch request for warp %0d already in flight", sched_wid);
      if (rsp_fire)
        assert (pend_mask[icache_rsp_tag]) else $error("icache response for idle tag %0d", icache_rsp_tag);
    end
  end
`endif

endmodule

// File: tb/tb_vx_fetch_queue.sv
// Random and directed stimulus for vx_fetch_queue, checked every cycle
// against a queue-based model of the fetch stage.
module tb_vx_fetch_queue;

  localparam int NW   = 4;
  localparam int MAXP = 3;
  localparam int FD_W = 2 + 4 + 30 + 44 + 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sched_valid = 1'b0;
  logic        sched_ready;
  logic [1:0]  sched_wid = '0;
  logic [3:0]  sched_tmask = '0;
  logic [29:0] sched_pc = '0;
  logic [43:0] sched_uuid = '0;
  logic        icache_req_valid;
  logic        icache_req_ready = 1'b0;
  logic [29:0] icache_req_addr;
  logic [1:0]  icache_req_tag;
  logic        icache_rsp_valid = 1'b0;
  logic        icache_rsp_ready;
  logic [31:0] icache_rsp_data = '0;
  logic [1:0]  icache_rsp_tag = '0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic [1:0]  fetch_wid;
  logic [3:0]  fetch_tmask;
  logic [29:0] fetch_pc;
  logic [43:0] fetch_uuid;
  logic [31:0] fetch_instr;
  logic [1:0]  pending_cnt;
  logic        busy;
  logic [31:0] perf_req_stalls;
  logic [31:0] perf_rsp_stalls;

  vx_fetch_queue #(.MAX_PENDING(MAXP)) dut (
    .clk(clk), .reset(reset),
    .sched_valid(sched_valid), .sched_ready(sched_ready), .sched_wid(sched_wid),
    .sched_tmask(sched_tmask), .sched_pc(sched_pc), .sched_uuid(sched_uuid),
    .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
    .icache_req_addr(icache_req_addr), .icache_req_tag(icache_req_tag),
    .icache_rsp_valid(icache_rsp_valid), .icache_rsp_ready(icache_rsp_ready),
    .icache_rsp_data(icache_rsp_data), .icache_rsp_tag(icache_rsp_tag),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_wid(fetch_wid),
    .fetch_tmask(fetch_tmask), .fetch_pc(fetch_pc), .fetch_uuid(fetch_uuid),
    .fetch_instr(fetch_instr), .pending_cnt(pending_cnt), .busy(busy),
    .perf_req_stalls(perf_req_stalls), .perf_rsp_stalls(perf_rsp_stalls)
  );

  // clock / reset
  always #5 clk = ~clk;

  // model state
  int          checks = 0;
  int          errors = 0;
  int          m_cnt = 0;
  bit          m_pend [NW];
  logic [3:0]  m_tmask [NW];
  logic [29:0] m_pc [NW];
  logic [43:0] m_uuid [NW];
  int          m_req_stalls = 0;
  int          m_rsp_stalls = 0;
  logic [FD_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_req_stalls = 0;
    m_rsp_stalls = 0;
    exp_q.delete();
    for (int i = 0; i < NW; i++) m_pend[i] = 1'b0;
  endtask

  // One cycle: drive at negedge, compare at negedge+1, advance model at posedge.
  task automatic step(input bit sv, input logic [1:0] wid, input logic [3:0] tm,
                      input logic [29:0] pc, input logic [43:0] uu, input bit qr,
                      input bit rv, input logic [1:0] rt, input logic [31:0] rd, input bit fr);
    bit credit, e_sready, e_qvalid, e_rrdy, e_fvalid, req_f, rsp_f, pop_f;
    logic [FD_W-1:0] head;
    sched_valid = sv; sched_wid = wid; sched_tmask = tm; sched_pc = pc; sched_uuid = uu;
    icache_req_ready = qr; icache_rsp_valid = rv; icache_rsp_tag = rt;
    icache_rsp_data = rd; fetch_ready = fr;
    #1;
    credit   = (m_cnt < MAXP);
    e_sready = qr && credit;
    e_qvalid = sv && credit;
    e_rrdy   = (exp_q.size() < 2);
    e_fvalid = (exp_q.size() != 0);
    chk("sched_ready", 64'(sched_ready), 64'(e_sready));
    chk("icache_req_valid", 64'(icache_req_valid), 64'(e_qvalid));
    if (e_qvalid) begin
      chk("icache_req_addr", 64'(icache_req_addr), 64'(pc));
      chk("icache_req_tag", 64'(icache_req_tag), 64'(wid));
    end
    chk("icache_rsp_ready", 64'(icache_rsp_ready), 64'(e_rrdy));
    chk("fetch_valid", 64'(fetch_valid), 64'(e_fvalid));
    if (e_fvalid) begin
      head = exp_q[0];
      chk("fetch_wid", 64'(fetch_wid), 64'(head[111:110]));
      chk("fetch_tmask", 64'(fetch_tmask), 64'(head[109:106]));
      chk("fetch_pc", 64'(fetch_pc), 64'(head[105:76]));
      chk("fetch_uuid", 64'(fetch_uuid), 64'(head[75:32]));
      chk("fetch_instr", 64'(fetch_instr), 64'(head[31:0]));
    end
    chk("pending_cnt", 64'(pending_cnt), 64'(m_cnt));
    chk("busy", 64'(busy), 64'((m_cnt != 0) || e_fvalid));
    chk("perf_req_stalls", 64'(perf_req_stalls), 64'(m_req_stalls));
    chk("perf_rsp_stalls", 64'(perf_rsp_stalls), 64'(m_rsp_stalls));
    req_f = sv && e_sready;
    rsp_f = rv && e_rrdy;
    pop_f = e_fvalid && fr;
    @(posedge clk);
    if (pop_f) void'(exp_q.pop_front());
    if (rsp_f) begin
      exp_q.push_back({rt, m_tmask[rt], m_pc[rt], m_uuid[rt], rd});
      m_pend[rt] = 1'b0;
      m_cnt--;
    end
    if (req_f) begin
      m_tmask[wid] = tm; m_pc[wid] = pc; m_uuid[wid] = uu;
      m_pend[wid] = 1'b1;
      m_cnt++;
    end
    if (sv && !e_sready) m_req_stalls++;
    if (rv && !e_rrdy) m_rsp_stalls++;
    @(negedge clk);
  endtask

  // driver tasks
  task automatic req(input logic [1:0] wid, input logic [29:0] pc);
    step(1'b1, wid, 4'($urandom_range(1, 15)), pc, {12'($urandom), 32'($urandom)},
         1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
  endtask

  task automatic rsp(input logic [1:0] tag, input logic [31:0] data, input bit fr);
    step(1'b0, 2'd0, 4'd0, 30'd0, 44'd0, 1'b0, 1'b1, tag, data, fr);
  endtask

  task automatic idle(input bit fr);
    step(1'b0, 2'd0, 4'd0, 30'd0, 44'd0, 1'b0, 1'b0, 2'd0, 32'd0, fr);
  endtask

  task automatic rand_step();
    int free_w[$];
    int busy_w[$];
    bit sv, rv;
    logic [1:0] wid, rt;
    for (int i = 0; i < NW; i++) begin
      if (m_pend[i]) busy_w.push_back(i);
      else free_w.push_back(i);
    end
    sv = (free_w.size() != 0) && ($urandom_range(0, 3) != 0);
    rv = (busy_w.size() != 0) && ($urandom_range(0, 2) != 0);
    wid = sv ? 2'(free_w[$urandom_range(0, free_w.size() - 1)]) : 2'd0;
    rt  = rv ? 2'(busy_w[$urandom_range(0, busy_w.size() - 1)]) : 2'd0;
    step(sv, wid, 4'($urandom), 30'($urandom), {12'($urandom), 32'($urandom)},
         1'($urandom_range(0, 3) != 0), rv, rt, $urandom, 1'($urandom_range(0, 2) != 0));
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && (m_cnt != 0 || exp_q.size() != 0); n++) begin
      int t = 0;
      for (int i = NW - 1; i >= 0; i--) if (m_pend[i]) t = i;
      if (m_cnt != 0) rsp(2'(t), $urandom, 1'b1);
      else idle(1'b1);
    end
    chk("drained", 64'(m_cnt + exp_q.size()), 64'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset pending_cnt", 64'(pending_cnt), 64'd0);
    chk("reset fetch_valid", 64'(fetch_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // single fetch
    req(2'd2, 30'h100);
    chk("single pending_cnt", 64'(pending_cnt), 64'd1);
    rsp(2'd2, 32'hDEADBEEF, 1'b0);
    chk("single fetch_valid", 64'(fetch_valid), 64'd1);
    chk("single fetch_wid", 64'(fetch_wid), 64'd2);
    chk("single fetch_pc", 64'(fetch_pc), 64'h100);
    chk("single fetch_instr", 64'(fetch_instr), 64'hDEADBEEF);
    chk("single pending back", 64'(pending_cnt), 64'd0);
    idle(1'b1);

    // out of order completion
    req(2'd0, 30'h200); req(2'd1, 30'h300); req(2'd2, 30'h400);
    rsp(2'd2, 32'h2222, 1'b1);
    chk("ooo first wid", 64'(fetch_wid), 64'd2);
    rsp(2'd0, 32'h0000, 1'b1);
    chk("ooo second pc", 64'(fetch_pc), 64'h200);
    rsp(2'd1, 32'h1111, 1'b1);
    chk("ooo third wid", 64'(fetch_wid), 64'd1);
    chk("ooo third instr", 64'(fetch_instr), 64'h1111);
    idle(1'b1);

    // credit limit: fourth request stalls until a response frees a slot
    req(2'd0, 30'h10); req(2'd1, 30'h11); req(2'd2, 30'h12);
    sched_valid = 1'b1; icache_req_ready = 1'b1; sched_wid = 2'd3;
    #1;
    chk("credit sched_ready", 64'(sched_ready), 64'd0);
    step(1'b1, 2'd3, 4'hF, 30'h13, 44'h13, 1'b1, 1'b1, 2'd1, 32'hAB, 1'b1);
    chk("credit freed", 64'(pending_cnt), 64'd2);
    req(2'd3, 30'h13);
    chk("credit refilled", 64'(pending_cnt), 64'd3);
    drain();

    // backpressure: two responses fill the buffer, third waits
    req(2'd0, 30'h20); req(2'd1, 30'h21); req(2'd2, 30'h22);
    rsp(2'd0, 32'hA0, 1'b0); rsp(2'd1, 32'hA1, 1'b0);
    chk("bp rsp_ready low", 64'(icache_rsp_ready), 64'd0);
    rsp(2'd2, 32'hA2, 1'b0);
    rsp(2'd2, 32'hA2, 1'b1);
    rsp(2'd2, 32'hA2, 1'b1);
    chk("bp third accepted", 64'(pending_cnt), 64'd0);
    drain();

    // simultaneous response and request for different warps
    req(2'd1, 30'h31);
    step(1'b1, 2'd3, 4'h5, 30'h33, 44'h33, 1'b1, 1'b1, 2'd1, 32'h31, 1'b1);
    chk("simul pending_cnt", 64'(pending_cnt), 64'd1);
    chk("simul fetch_wid", 64'(fetch_wid), 64'd1);
    drain();

    // randomized traffic
    for (int n = 0; n < 400; n++) rand_step();
    drain();

    // reset with three requests pending and a full buffer
    req(2'd0, 30'h40); req(2'd1, 30'h41); req(2'd2, 30'h42);
    rsp(2'd0, 32'hB0, 1'b0); rsp(2'd1, 32'hB1, 1'b0);
    req(2'd0, 30'h43); req(2'd1, 30'h44);
    chk("pre-reset pending", 64'(pending_cnt), 64'd3);
    #2 reset = 1'b0;
    #1;
    chk("mid reset pending_cnt", 64'(pending_cnt), 64'd0);
    chk("mid reset fetch_valid", 64'(fetch_valid), 64'd0);
    chk("mid reset busy", 64'(busy), 64'd0);
    chk("mid reset perf", 64'(perf_req_stalls | perf_rsp_stalls), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    req(2'd0, 30'h50);
    rsp(2'd0, 32'hC0DE, 1'b0);
    chk("post reset wid", 64'(fetch_wid), 64'd0);
    chk("post reset pc", 64'(fetch_pc), 64'h50);
    chk("post reset instr", 64'(fetch_instr), 64'hC0DE);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
